// File: rtl/pipeline_latealu_ctrl.sv
// pipeline_latealu_ctrl
// Arbitrates two shift requesters onto a shared one-cycle-latency shifter ALU,
// keeps destination/tag/source metadata aligned with the registered ALU result,
// and presents the result as a valid/ready writeback. While the writeback is
// stalled the ALU is driven with the hold opcode so its result stays put.
module pipeline_latealu_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_a0,
    input  logic [31:0]      req0_a1,
    input  logic [REG_W-1:0] req0_rd,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_a0,
    input  logic [31:0]      req1_a1,
    input  logic [REG_W-1:0] req1_rd,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [5:0]       alu_op,
    output logic [31:0]      alu_a0,
    output logic [31:0]      alu_a1,
    input  logic [31:0]      alu_result,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [REG_W-1:0] wb_rd,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_src,

    output logic             busy_valid,
    output logic [REG_W-1:0] busy_rd
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ALUOP_W = 6;

    localparam logic [1:0] REQ_MOV = 2'b00;
    localparam logic [1:0] REQ_SLL = 2'b01;
    localparam logic [1:0] REQ_SRL = 2'b10;
    localparam logic [1:0] REQ_SRA = 2'b11;

    localparam logic [ALUOP_W-1:0] ALU_HOLD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(3);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_PEND  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               src_q, src_d;
    logic               last_grant_q, last_grant_d;

    logic               pend;
    logic               slot_free;
    logic               issue_ok;
    logic               grant;
    logic               issue;
    logic [1:0]         sel_op;
    logic [DATA_W-1:0]  sel_a0;
    logic [DATA_W-1:0]  sel_a1;
    logic [REG_W-1:0]   sel_rd;
    logic [TAG_W-1:0]   sel_tag;

    // Round-robin grant and issue qualification; a tie goes to the requester that did not win last.
    always_comb begin
        pend      = (state_q == ST_PEND);
        slot_free = !pend || wb_ready;
        issue_ok  = slot_free && !flush && !rst;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = !last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        issue      = issue_ok && (req0_valid || req1_valid);
        req0_ready = issue && !grant;
        req1_ready = issue && grant;
        sel_op     = grant ? req1_op  : req0_op;
        sel_a0     = grant ? req1_a0  : req0_a0;
        sel_a1     = grant ? req1_a1  : req0_a1;
        sel_rd     = grant ? req1_rd  : req0_rd;
        sel_tag    = grant ? req1_tag : req0_tag;
    end

    // ALU drive: granted request's operands on issue, hold opcode with zero operands otherwise.
    always_comb begin
        alu_op = ALU_HOLD;
        alu_a0 = '0;
        alu_a1 = '0;
        if (issue) begin
            alu_a0 = sel_a0;
            alu_a1 = sel_a1;
            unique case (sel_op)
                REQ_MOV: begin
                    alu_op = ALU_SLL;
                    alu_a1 = '0;
                end
                REQ_SLL: alu_op = ALU_SLL;
                REQ_SRL: alu_op = ALU_SRL;
                REQ_SRA: alu_op = ALU_SRA;
                default: alu_op = ALU_HOLD;
            endcase
        end
    end

    // Writeback slot next state: flush kills, issue (re)loads, accept without issue empties.
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        tag_d        = tag_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        if (issue) begin
            rd_d         = sel_rd;
            tag_d        = sel_tag;
            src_d        = grant;
            last_grant_d = grant;
        end
        unique case (state_q)
            ST_EMPTY: begin
                if (issue) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (issue) begin
                    state_d = ST_PEND;
                end else if (wb_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State and metadata registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            rd_q         <= '0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wb_valid   = (state_q == ST_PEND);
    assign wb_data    = alu_result;
    assign wb_rd      = rd_q;
    assign wb_tag     = tag_q;
    assign wb_src     = src_q;
    assign busy_valid = wb_valid && (rd_q != '0);
    assign busy_rd    = rd_q;

endmodule

// File: tb/tb_pipeline_latealu_ctrl.sv
// Bench for pipeline_latealu_ctrl: directed vectors with hand-computed results,
// a scoreboard queue filled on accepted requests and drained by a writeback monitor.
module tb_pipeline_latealu_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic             v;
        logic [1:0]       op;
        logic [31:0]      a0;
        logic [31:0]      a1;
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } req_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
        logic             src;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [31:0]      req0_a0 = '0, req0_a1 = '0, req1_a0 = '0, req1_a1 = '0;
    logic [REG_W-1:0] req0_rd = '0, req1_rd = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [5:0]       alu_op;
    logic [31:0]      alu_a0, alu_a1;
    logic [31:0]      alu_result = '0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [31:0]      wb_data;
    logic [REG_W-1:0] wb_rd;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_src;
    logic             busy_valid;
    logic [REG_W-1:0] busy_rd;

    logic [31:0]      exp0 = '0, exp1 = '0;
    wb_t              sb_q[$];
    int               errors = 0;
    int               checks = 0;

    pipeline_latealu_ctrl #(.REG_W(REG_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a0(req0_a0), .req0_a1(req0_a1), .req0_rd(req0_rd), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a0(req1_a0), .req1_a1(req1_a1), .req1_rd(req1_rd), .req1_tag(req1_tag),
        .alu_op(alu_op), .alu_a0(alu_a0), .alu_a1(alu_a1), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_src(wb_src),
        .busy_valid(busy_valid), .busy_rd(busy_rd)
    );

    always #5 clk = ~clk;

    // Behavioural late shifter ALU: registered result, opcode 0 holds.
    always @(posedge clk) begin
        case (alu_op)
            6'd1: alu_result <= alu_a0 << alu_a1[4:0];
            6'd2: alu_result <= alu_a0 >> alu_a1[4:0];
            6'd3: alu_result <= $unsigned($signed(alu_a0) >>> alu_a1[4:0]);
            default: alu_result <= alu_result;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic v, input logic [1:0] op, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [REG_W-1:0] rd,
                                input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        req_t r;
        r.v = v; r.op = op; r.a0 = a0; r.a1 = a1; r.rd = rd; r.tag = tag; r.exp = exp;
        return r;
    endfunction

    // One cycle of stimulus: drive after the rising edge, check readies at the falling edge.
    task automatic cyc(input req_t r0, input req_t r1, input logic wbr, input logic fl,
                       input logic rs, input logic er0, input logic er1);
        @(posedge clk);
        #1;
        req0_valid = r0.v; req0_op = r0.op; req0_a0 = r0.a0; req0_a1 = r0.a1;
        req0_rd = r0.rd; req0_tag = r0.tag; exp0 = r0.exp;
        req1_valid = r1.v; req1_op = r1.op; req1_a0 = r1.a0; req1_a1 = r1.a1;
        req1_rd = r1.rd; req1_tag = r1.tag; exp1 = r1.exp;
        wb_ready = wbr; flush = fl; rst = rs;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(er0));
        chk("req1_ready", 32'(req1_ready), 32'(er1));
    endtask

    // Scoreboard fill: drop a writeback killed by flush/reset, push each accepted request.
    always @(negedge clk) begin
        #1;
        if ((flush || rst) && wb_valid === 1'b1 && sb_q.size() > 0) begin
            void'(sb_q.pop_back());
        end
        if (req0_valid && req0_ready === 1'b1) sb_q.push_back('{exp0, req0_rd, req0_tag, 1'b0});
        if (req1_valid && req1_ready === 1'b1) sb_q.push_back('{exp1, req1_rd, req1_tag, 1'b1});
    end

    // Writeback monitor: compare every retired writeback against the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1 && wb_ready && !flush && !rst) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got data %h rd %0d with nothing expected", wb_data, wb_rd);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_tag", 32'(wb_tag), 32'(e.tag));
                chk("wb_src", 32'(wb_src), 32'(e.src));
            end
        end
    end

    initial begin
        req_t n, s0, s1, r0, r1;
        n = mk(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 4'd0, 32'h0);

        // Reset state
        cyc(n, n, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(n, n, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_tag", 32'(wb_tag), 32'd0);
        chk("rst_wb_src", 32'(wb_src), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);

        // Both valid from reset: req0 wins first tie, then strict alternation without bubbles
        s0 = mk(1'b1, 2'b01, 32'h1, 32'd4, 5'd3, 4'd5, 32'h10);
        s1 = mk(1'b1, 2'b11, 32'h8000_0000, 32'd31, 5'd7, 4'd9, 32'hFFFF_FFFF);
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sll_alu_op", 32'(alu_op), 32'd1);
        chk("sll_alu_a1", alu_a1, 32'd4);
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("alt_wb_valid1", 32'(wb_valid), 32'd1);
        chk("alt_busy_valid", 32'(busy_valid), 32'd1);
        chk("alt_busy_rd", 32'(busy_rd), 32'd3);
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("alt_wb_valid2", 32'(wb_valid), 32'd1);
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("alt_wb_valid3", 32'(wb_valid), 32'd1);

        // srl of the sign bit, then mov to r0 (busy must stay low)
        r1 = mk(1'b1, 2'b10, 32'h8000_0000, 32'd31, 5'd7, 4'd2, 32'h1);
        cyc(n, r1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        r0 = mk(1'b1, 2'b00, 32'hDEAD_BEEF, 32'd7, 5'd0, 4'd4, 32'hDEAD_BEEF);
        cyc(r0, n, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mov_alu_op", 32'(alu_op), 32'd1);
        chk("mov_alu_a0", alu_a0, 32'hDEAD_BEEF);
        chk("mov_alu_a1", alu_a1, 32'd0);
        cyc(n, n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mov_wb_valid", 32'(wb_valid), 32'd1);
        chk("mov_busy_valid", 32'(busy_valid), 32'd0);
        chk("mov_wb_data", wb_data, 32'hDEAD_BEEF);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_wb_valid", 32'(wb_valid), 32'd0);

        // Stall for three cycles with both requesters waiting, then release
        r0 = mk(1'b1, 2'b01, 32'h3, 32'd8, 5'd12, 4'd1, 32'h300);
        cyc(r0, n, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        s0 = mk(1'b1, 2'b10, 32'hF0, 32'd4, 5'd13, 4'd3, 32'hF);
        s1 = mk(1'b1, 2'b01, 32'h1, 32'd31, 5'd14, 4'd6, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            cyc(s0, s1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_alu_op", 32'(alu_op), 32'd0);
            chk("stall_wb_valid", 32'(wb_valid), 32'd1);
            chk("stall_wb_data", wb_data, 32'h300);
            chk("stall_wb_rd", 32'(wb_rd), 32'd12);
        end
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("release_alu_op", 32'(alu_op), 32'd1);
        cyc(s0, n, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush beats wb_ready and a same-cycle request; last grant unchanged
        r1 = mk(1'b1, 2'b01, 32'h5, 32'd1, 5'd9, 4'd7, 32'hA);
        cyc(n, r1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        r0 = mk(1'b1, 2'b01, 32'h1, 32'd1, 5'd4, 4'd2, 32'h2);
        cyc(r0, n, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_alu_op", 32'(alu_op), 32'd0);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);
        s0 = mk(1'b1, 2'b11, 32'hF000_0000, 32'd4, 5'd2, 4'd8, 32'hFF00_0000);
        s1 = mk(1'b1, 2'b10, 32'hF000_0000, 32'd4, 5'd6, 4'd1, 32'h0F00_0000);
        cyc(s0, s1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with a pending writeback, then first tie goes to req0 again
        cyc(s0, s1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        s0 = mk(1'b1, 2'b01, 32'h1, 32'd0, 5'd1, 4'hF, 32'h1);
        cyc(s0, s1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_alu_a0", alu_a0, 32'h1);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
        cyc(n, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_wb_valid", 32'(wb_valid), 32'd0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
